// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle for dmem_arbiter.
// slave = arbiter view; master = requesters plus memory unit.
`timescale 1ns/1ps
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [63:0]       core_wdata;
    logic [1:0]        core_width;
    logic              core_sext;
    logic              core_ack;
    logic              core_err;
    logic [63:0]       core_rdata;
    logic              core_stall;

    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [63:0]       aux_wdata;
    logic [1:0]        aux_width;
    logic              aux_sext;
    logic              aux_ack;
    logic              aux_err;
    logic [63:0]       aux_rdata;

    logic              mem_en;
    logic              mem_wea;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_din;
    logic [1:0]        mem_bit_width;
    logic              mem_sign_extend;
    logic [63:0]       mem_dout;

    logic              busy;
    logic              grant;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_width, core_sext,
        output core_ack, core_err, core_rdata, core_stall,
        input  aux_req, aux_we, aux_addr, aux_wdata, aux_width, aux_sext,
        output aux_ack, aux_err, aux_rdata,
        output mem_en, mem_wea, mem_addr, mem_din, mem_bit_width, mem_sign_extend,
        input  mem_dout,
        output busy, grant
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_width, core_sext,
        input  core_ack, core_err, core_rdata, core_stall,
        output aux_req, aux_we, aux_addr, aux_wdata, aux_width, aux_sext,
        input  aux_ack, aux_err, aux_rdata,
        input  mem_en, mem_wea, mem_addr, mem_din, mem_bit_width, mem_sign_extend,
        output mem_dout,
        input  busy, grant
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin core/aux arbiter for the data memory; ack LAT+1 cycles after grant, misaligned acks+errs after 1.
// Requesters hold req until ack; the loser simply waits, core stall is req & ~ack.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int LAT    = 2
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_grant_q;
    logic              grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [1:0]        width_q;
    logic              sext_q;

    logic              any_req;
    logic              grant_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [63:0]       wdata_d;
    logic [1:0]        width_d;
    logic              sext_d;
    logic              misalign_d;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        any_req = bus.core_req | bus.aux_req;
        grant_d = (bus.core_req & bus.aux_req) ? ~last_grant_q : bus.aux_req;
        we_d    = grant_d ? bus.aux_we    : bus.core_we;
        addr_d  = grant_d ? bus.aux_addr  : bus.core_addr;
        wdata_d = grant_d ? bus.aux_wdata : bus.core_wdata;
        width_d = grant_d ? bus.aux_width : bus.core_width;
        sext_d  = grant_d ? bus.aux_sext  : bus.core_sext;
        unique case (width_d)
            2'b01:   misalign_d = addr_d[0];
            2'b10:   misalign_d = |addr_d[1:0];
            2'b11:   misalign_d = |addr_d[2:0];
            default: misalign_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            width_q      <= 2'b00;
            sext_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        we_q         <= we_d;
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        width_q      <= width_d;
                        sext_q       <= sext_d;
                        cnt_q        <= '0;
                        state_q      <= misalign_d ? ERR : BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                    end
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic        in_busy;
    logic        in_err;
    logic        done;
    logic        ack;
    logic [63:0] rdata;

    assign in_busy = (state_q == BUSY);
    assign in_err  = (state_q == ERR);
    assign done    = in_busy & (cnt_q == CNT_LAST);
    assign ack     = done | in_err;
    // Stores return zero; loads pass the memory output through on the ack cycle.
    assign rdata   = (done & ~we_q) ? bus.mem_dout : 64'd0;

    assign bus.core_ack   = ack & ~grant_q;
    assign bus.core_err   = in_err & ~grant_q;
    assign bus.core_rdata = grant_q ? 64'd0 : rdata;
    assign bus.core_stall = bus.core_req & ~bus.core_ack;

    assign bus.aux_ack    = ack & grant_q;
    assign bus.aux_err    = in_err & grant_q;
    assign bus.aux_rdata  = grant_q ? rdata : 64'd0;

    // Write enable only on the first busy cycle so each store hits memory once.
    assign bus.mem_en          = in_busy;
    assign bus.mem_wea         = in_busy & we_q & (cnt_q == '0);
    assign bus.mem_addr        = in_busy ? addr_q : '0;
    assign bus.mem_din         = in_busy ? wdata_q : 64'd0;
    assign bus.mem_bit_width   = in_busy ? width_q : 2'b00;
    assign bus.mem_sign_extend = in_busy & sext_q;

    assign bus.busy  = (state_q != IDLE);
    assign bus.grant = grant_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(64)) bus ();

    dmem_arbiter #(.ADDR_W(64), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory environment: fixed read latency, background pattern for untouched bytes.
    function automatic logic [63:0] pat(input logic [7:0] a);
        return {a, ~a, a ^ 8'h3c, 8'h5a, a, 8'hc3, ~a, a + 8'd1};
    endfunction

    logic [63:0] env_mem [256];
    bit          written [256];
    logic [63:0] pipe    [LAT];
    int          wr_count = 0;
    logic        pre_vld  = 1'b0;
    logic [7:0]  pre_addr = 8'h0;
    logic [63:0] pre_dat  = 64'h0;

    always @(posedge clk) begin
        logic [7:0] a;
        a = bus.mem_addr[7:0];
        if (pre_vld) begin
            env_mem[pre_addr] <= pre_dat;
            written[pre_addr] <= 1'b1;
        end
        if (bus.mem_en && bus.mem_wea) begin
            env_mem[a] <= bus.mem_din;
            written[a] <= 1'b1;
            wr_count   <= wr_count + 1;
        end
        pipe[0] <= bus.mem_en ? (written[a] ? env_mem[a] : pat(a)) : 64'h0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_dout = pipe[LAT-1];

    task automatic idle_inputs();
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.core_width = 0; bus.core_sext = 0;
        bus.aux_req = 0; bus.aux_we = 0; bus.aux_addr = '0; bus.aux_wdata = '0;
        bus.aux_width = 0; bus.aux_sext = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preset(input logic [7:0] a, input logic [63:0] d);
        @(negedge clk);
        pre_vld = 1'b1; pre_addr = a; pre_dat = d;
        @(negedge clk);
        pre_vld = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.grant, bus.mem_en, bus.mem_wea, bus.core_ack, bus.aux_ack,
             bus.core_err, bus.aux_err} !== 8'h00) begin
            $display("FAIL reset_ctrl: got %b want 00000000", {bus.busy, bus.grant, bus.mem_en,
                     bus.mem_wea, bus.core_ack, bus.aux_ack, bus.core_err, bus.aux_err});
            n_fail++;
        end
        n_cmp++;
        if ({bus.core_rdata, bus.aux_rdata, bus.mem_addr, bus.mem_din} !== 256'h0) begin
            $display("FAIL reset_data: core_rdata %h aux_rdata %h mem_addr %h want 0",
                     bus.core_rdata, bus.aux_rdata, bus.mem_addr);
            n_fail++;
        end
        rst = 1'b0;
        bus.core_req = 1'b1;
        #1;
        n_cmp++;
        if (bus.core_stall !== 1'b1) begin
            $display("FAIL reset_stall: got %b want 1", bus.core_stall);
            n_fail++;
        end
        bus.core_req = 1'b0;
    endtask

    task automatic test_core_load();
        preset(8'h40, 64'h1122334455667788);
        do_reset();
        bus.core_req = 1; bus.core_we = 0; bus.core_addr = 64'h40; bus.core_width = 2'b11;
        #1;
        n_cmp++;
        if ({bus.core_stall, bus.mem_en} !== 2'b10) begin
            $display("FAIL load_first: stall,en got %b want 10", {bus.core_stall, bus.mem_en});
            n_fail++;
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.mem_en, bus.core_ack, bus.core_stall, bus.aux_ack, bus.mem_wea} !==
                {k <= 3, k == 3, k < 3, 1'b0, 1'b0}) begin
                $display("FAIL load_seq k=%0d: en,ack,stall,aux_ack,wea got %b", k,
                         {bus.mem_en, bus.core_ack, bus.core_stall, bus.aux_ack, bus.mem_wea});
                n_fail++;
            end
            if (k <= 3) begin
                n_cmp++;
                if ({bus.mem_addr, bus.mem_bit_width, bus.mem_sign_extend} !== {64'h40, 2'b11, 1'b0}) begin
                    $display("FAIL load_mem k=%0d: addr %h width %b sext %b", k, bus.mem_addr,
                             bus.mem_bit_width, bus.mem_sign_extend);
                    n_fail++;
                end
            end
            if (k == 3) begin
                n_cmp++;
                if (bus.core_rdata !== 64'h1122334455667788) begin
                    $display("FAIL load_rdata: got %h want 1122334455667788", bus.core_rdata);
                    n_fail++;
                end
                bus.core_req = 0;
            end
        end
    endtask

    task automatic test_core_store();
        int wr0;
        do_reset();
        wr0 = wr_count;
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 64'h10;
        bus.core_wdata = 64'hDEADBEEF; bus.core_width = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.mem_en, bus.mem_wea, bus.core_ack} !== {1'b1, k == 1, k == 3}) begin
                $display("FAIL store_seq k=%0d: en,wea,ack got %b", k,
                         {bus.mem_en, bus.mem_wea, bus.core_ack});
                n_fail++;
            end
            if (k == 1) begin
                n_cmp++;
                if ({bus.mem_addr, bus.mem_din} !== {64'h10, 64'hDEADBEEF}) begin
                    $display("FAIL store_bus: addr %h din %h want 10 deadbeef", bus.mem_addr, bus.mem_din);
                    n_fail++;
                end
            end
            if (k == 3) begin
                n_cmp++;
                if (bus.core_rdata !== 64'h0) begin
                    $display("FAIL store_rdata: got %h want 0", bus.core_rdata);
                    n_fail++;
                end
                bus.core_req = 0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if ((wr_count - wr0) !== 1 || env_mem[8'h10] !== 64'hDEADBEEF) begin
            $display("FAIL store_count: writes %0d mem %h want 1 deadbeef", wr_count - wr0, env_mem[8'h10]);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int who [4];
        int at  [4];
        int n;
        do_reset();
        n = 0;
        bus.core_req = 1; bus.core_addr = 64'h80; bus.core_width = 2'b11;
        bus.aux_req  = 1; bus.aux_addr  = 64'h88; bus.aux_width  = 2'b11;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.core_ack && bus.aux_ack) begin
                $display("FAIL b2b_both_ack: cycle %0d", c);
                n_fail++;
            end
            if ((bus.core_ack || bus.aux_ack) && n < 4) begin
                who[n] = bus.aux_ack ? 1 : 0;
                at[n]  = c;
                n_cmp++;
                if ((bus.aux_ack ? bus.aux_rdata : bus.core_rdata) !== pat(bus.aux_ack ? 8'h88 : 8'h80)) begin
                    $display("FAIL b2b_rdata n=%0d: got %h", n, bus.aux_ack ? bus.aux_rdata : bus.core_rdata);
                    n_fail++;
                end
                n++;
            end
        end
        n_cmp++;
        if (n !== 4) begin
            $display("FAIL b2b_count: got %0d acks want 4", n);
            n_fail++;
        end
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (who[i] !== (i % 2) || at[i] !== 3 + 4 * i) begin
                $display("FAIL b2b_order i=%0d: who %0d at %0d want %0d at %0d", i, who[i], at[i], i % 2, 3 + 4 * i);
                n_fail++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_misaligned();
        do_reset();
        bus.aux_req = 1; bus.aux_we = 0; bus.aux_addr = 64'h3; bus.aux_width = 2'b01;
        @(negedge clk);
        n_cmp++;
        if ({bus.aux_ack, bus.aux_err, bus.core_ack, bus.mem_en, bus.aux_rdata} !== {4'b1100, 64'h0}) begin
            $display("FAIL misalign: ack,err,core_ack,en got %b rdata %h",
                     {bus.aux_ack, bus.aux_err, bus.core_ack, bus.mem_en}, bus.aux_rdata);
            n_fail++;
        end
        bus.aux_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({bus.aux_ack, bus.busy, bus.mem_en} !== 3'b000) begin
            $display("FAIL misalign_after: ack,busy,en got %b", {bus.aux_ack, bus.busy, bus.mem_en});
            n_fail++;
        end
        bus.aux_req = 1; bus.aux_addr = 64'h8; bus.aux_width = 2'b11;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.mem_en, bus.aux_ack, bus.aux_err} !== {1'b1, k == 3, 1'b0}) begin
                $display("FAIL dbl_seq k=%0d: en,ack,err got %b", k, {bus.mem_en, bus.aux_ack, bus.aux_err});
                n_fail++;
            end
        end
        n_cmp++;
        if (bus.aux_rdata !== pat(8'h08)) begin
            $display("FAIL dbl_rdata: got %h want %h", bus.aux_rdata, pat(8'h08));
            n_fail++;
        end
        bus.aux_req = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.core_req = 1; bus.core_addr = 64'h40; bus.core_width = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.mem_en, bus.core_ack, bus.mem_wea} !== 4'b0000) begin
            $display("FAIL rst_mid: busy,en,ack,wea got %b", {bus.busy, bus.mem_en, bus.core_ack, bus.mem_wea});
            n_fail++;
        end
        rst = 1'b0;
        bus.core_req = 0;
        @(negedge clk);
        bus.core_req = 1; bus.core_addr = 64'h90;
        bus.aux_req  = 1; bus.aux_addr  = 64'h98; bus.aux_width = 2'b11;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.core_ack, bus.aux_ack, bus.grant} !== {k == 3, 1'b0, 1'b0}) begin
                $display("FAIL rst_tie k=%0d: core_ack,aux_ack,grant got %b", k,
                         {bus.core_ack, bus.aux_ack, bus.grant});
                n_fail++;
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        do_reset();
        bus.core_req = 1; bus.core_addr = 64'h48; bus.core_width = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.core_ack, bus.aux_ack, bus.busy} !== {k == 3, k == 7, k != 4}) begin
                $display("FAIL drop_seq k=%0d: core_ack,aux_ack,busy got %b", k,
                         {bus.core_ack, bus.aux_ack, bus.busy});
                n_fail++;
            end
            if (bus.busy) begin
                n_cmp++;
                if ({bus.grant, bus.mem_addr} !== {k >= 5, (k >= 5) ? 64'h98 : 64'h48}) begin
                    $display("FAIL drop_owner k=%0d: grant %b addr %h", k, bus.grant, bus.mem_addr);
                    n_fail++;
                end
            end
            if (k == 1) begin
                bus.core_req = 0; bus.core_addr = 64'h50;
                bus.aux_req = 1; bus.aux_addr = 64'h98; bus.aux_width = 2'b11;
            end
            if (k == 3) begin
                n_cmp++;
                if (bus.core_rdata !== pat(8'h48)) begin
                    $display("FAIL drop_rdata: got %h want %h", bus.core_rdata, pat(8'h48));
                    n_fail++;
                end
            end
            if (k == 7) begin
                n_cmp++;
                if (bus.aux_rdata !== pat(8'h98)) begin
                    $display("FAIL drop_aux_rdata: got %h want %h", bus.aux_rdata, pat(8'h98));
                    n_fail++;
                end
                bus.aux_req = 0;
            end
        end
    endtask

    // Transaction-level model: each access occupies the memory from grant until the
    // cycle after its ack; ties go to whoever did not win last; stores land in ref_mem at grant.
    task automatic test_random();
        logic [63:0] ref_mem [256];
        bit          rq [2];
        bit          wq [2];
        logic [7:0]  aq [2];
        logic [63:0] dq [2];
        logic [1:0]  wdq [2];
        bit          sq [2];
        bit          e_ack [2];
        bit          pending, e_mis, e_we, e_busy, e_en, e_wea;
        int          owner, last, gnt_at, ack_at, free_at, exp_wr, wr0;
        logic [7:0]  e_addr;
        logic [63:0] e_rd, e_din;
        logic [64:0] obs;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
        do_reset();
        pending = 0; last = 1; free_at = 0; exp_wr = 0; wr0 = wr_count;
        owner = 0; gnt_at = 0; ack_at = 0; e_mis = 0; e_we = 0; e_addr = 0; e_rd = 0; e_din = 0;
        for (int r = 0; r < 2; r++) begin
            rq[r] = 0; wq[r] = 0; aq[r] = 0; dq[r] = 0; wdq[r] = 0; sq[r] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            e_busy = pending && c > gnt_at && c <= ack_at;
            e_en   = e_busy && !e_mis;
            e_wea  = e_en && e_we && c == gnt_at + 1;
            for (int r = 0; r < 2; r++) e_ack[r] = pending && c == ack_at && owner == r;
            n_cmp++;
            if ({bus.core_ack, bus.aux_ack, bus.busy, bus.mem_en, bus.mem_wea, bus.core_stall} !==
                {e_ack[0], e_ack[1], e_busy, e_en, e_wea, rq[0] & ~e_ack[0]}) begin
                $display("FAIL rand_ctrl c=%0d: got %b want %b", c,
                         {bus.core_ack, bus.aux_ack, bus.busy, bus.mem_en, bus.mem_wea, bus.core_stall},
                         {e_ack[0], e_ack[1], e_busy, e_en, e_wea, rq[0] & ~e_ack[0]});
                n_fail++;
            end
            if (e_en) begin
                n_cmp++;
                if ({bus.grant, bus.mem_addr, bus.mem_din} !== {owner[0], 56'h0, e_addr, e_din}) begin
                    $display("FAIL rand_bus c=%0d: grant %b addr %h din %h want %0d %h %h", c,
                             bus.grant, bus.mem_addr, bus.mem_din, owner, e_addr, e_din);
                    n_fail++;
                end
            end
            if (e_ack[0] || e_ack[1]) begin
                obs = (owner == 1) ? {bus.aux_err, bus.aux_rdata} : {bus.core_err, bus.core_rdata};
                n_cmp++;
                if (obs !== {e_mis, e_rd}) begin
                    $display("FAIL rand_resp c=%0d: err,rdata got %h want %h", c, obs, {e_mis, e_rd});
                    n_fail++;
                end
                pending = 0;
            end
            for (int r = 0; r < 2; r++) begin
                if (!rq[r] || e_ack[r]) begin
                    rq[r]  = (c < 2900) && ($urandom_range(0, 2) != 0);
                    wq[r]  = 1'($urandom_range(0, 1));
                    aq[r]  = {1'b1, 7'($urandom_range(0, 127))};
                    if ($urandom_range(0, 3) != 0) aq[r][2:0] = 3'b000;
                    dq[r]  = {$urandom, $urandom};
                    wdq[r] = 2'($urandom_range(0, 3));
                    sq[r]  = 1'($urandom_range(0, 1));
                end
            end
            bus.core_req = rq[0]; bus.core_we = wq[0]; bus.core_addr = {56'h0, aq[0]};
            bus.core_wdata = dq[0]; bus.core_width = wdq[0]; bus.core_sext = sq[0];
            bus.aux_req = rq[1]; bus.aux_we = wq[1]; bus.aux_addr = {56'h0, aq[1]};
            bus.aux_wdata = dq[1]; bus.aux_width = wdq[1]; bus.aux_sext = sq[1];
            if (!pending && c >= free_at && (rq[0] || rq[1])) begin
                owner  = (rq[0] && rq[1]) ? (last == 1 ? 0 : 1) : (rq[1] ? 1 : 0);
                last   = owner;
                e_we   = wq[owner];
                e_addr = aq[owner];
                e_din  = dq[owner];
                e_mis  = (int'(aq[owner]) % (1 << wdq[owner])) != 0;
                gnt_at = c;
                ack_at = e_mis ? c + 1 : c + LAT + 1;
                free_at = ack_at + 1;
                pending = 1;
                e_rd = (!e_mis && !e_we) ? ref_mem[e_addr] : 64'h0;
                if (!e_mis && e_we) begin
                    ref_mem[e_addr] = e_din;
                    exp_wr++;
                end
            end
        end
        idle_inputs();
        repeat (LAT + 3) @(negedge clk);
        n_cmp++;
        if ((wr_count - wr0) !== exp_wr) begin
            $display("FAIL rand_writes: got %0d want %0d", wr_count - wr0, exp_wr);
            n_fail++;
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_core_load();
        test_core_store();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
        test_drop_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the interleaved data-memory unit between two requesters: the core load/store path and an auxiliary port (program loader / debug).
- Hides the fixed memory read latency behind a req/ack handshake. The core's memory stall is derived directly from its handshake.
- Performs round-robin arbitration and alignment checking, and drives the memory unit's enable, write, width and sign-extend controls from registered state.

Parameters:
ADDR_W, 64, width of request and memory addresses
LAT, 2, memory latency in cycles from enable/address to valid mem_dout (LAT >= 1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
core_req  input  1  core access request; held with stable fields until core_ack
core_we  input  1  1 = store, 0 = load
core_addr  input  ADDR_W  byte address
core_wdata  input  64  store data
core_width  input  2  00 byte, 01 half, 10 word, 11 double
core_sext  input  1  sign-extend load result
core_ack  output  1  one-cycle completion pulse
core_err  output  1  misaligned access flag, valid with core_ack
core_rdata  output  64  load data, valid with core_ack
core_stall  output  1  core_req & ~core_ack
aux_req, aux_we, aux_addr, aux_wdata, aux_width, aux_sext  input  1/1/ADDR_W/64/2/1  same as core
aux_ack, aux_err, aux_rdata  output  1/1/64  same as core
mem_en  output  1  memory enable
mem_wea  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_din  output  64  memory write data
mem_bit_width  output  2  access width to memory
mem_sign_extend  output  1  sign-extend control to memory
mem_dout  input  64  memory read data
busy  output  1  state != IDLE
grant  output  1  owner of the current transaction: 0 = core, 1 = aux

Behaviour:
- Reset values: state IDLE, cnt 0, last_grant 1 (so core wins the first tie), grant 0.
- All ack/err/rdata outputs and all mem_* outputs are 0 at reset and whenever IDLE.
- State IDLE:
  - No request: stay IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester that is not last_grant.
  - On grant: latch we, addr, wdata, width and sext into registers; set grant and last_grant.
  - Misaligned request goes to ERR. Misaligned means addr[0] != 0 for half, addr[1:0] != 0 for word, addr[2:0] != 0 for double.
  - Aligned request goes to BUSY with cnt = 0.
- State BUSY:
  - mem_en = 1, and mem_addr, mem_din, mem_bit_width, mem_sign_extend come from the latched registers.
  - mem_wea = latched we & (cnt == 0), giving exactly one write per store.
  - cnt increments each cycle.
  - When cnt == LAT: pulse the granted ack, drive its rdata = mem_dout (0 for stores), and go to IDLE at the next edge.
- State ERR: pulse the granted ack and err for one cycle, rdata = 0, no memory enable; go to IDLE next.
- Latency:
  - Request first seen in IDLE at cycle T gives ack at T+LAT+1 (T+3 for LAT = 2).
  - Misaligned request gives ack+err at T+1.
- Back-to-back: IDLE is re-entered one cycle after ack, so a requester holding req sees its next grant evaluated there. With both requesters continuously requesting, grants strictly alternate.
- Handshake rules:
  - Requester fields are sampled only at grant; later changes are ignored.
  - Dropping req mid-transaction does not abort: the access completes and ack still pulses.
  - The non-granted requester's ack stays 0.
- Reset mid-transaction: return to IDLE immediately, with no ack, no further mem_en/mem_wea, and last_grant = 1. A store already issued with wea is not undone.
- core_stall is combinational; it is high from core_req until and excluding the core_ack cycle.

Test Plan:
- Core load, addr 0x40, width 11, mem_dout model returns 0x1122334455667788 two cycles after en; req at cycle 5 -> mem_en high at cycles 6-8, core_ack and core_rdata = 0x1122334455667788 at cycle 8, core_stall high cycles 5-7.
- Core store, addr 0x10, wdata 0xDEADBEEF, width 10 -> mem_wea high only in the first BUSY cycle, with mem_addr 0x10 and mem_din 0xDEADBEEF; core_ack after 3 cycles with rdata 0.
- Core and aux both request continuously from reset -> grant sequence core, aux, core, aux; each ack spaced 4 cycles apart; the non-granted ack never asserts.
- Aux half load at addr 0x3 -> aux_ack and aux_err one cycle later, mem_en never asserts, aux_rdata 0. A double access at 0x8 proceeds normally.
- rst asserted during the second BUSY cycle of a core load -> next cycle busy = 0, mem_en = 0, no core_ack. A subsequent core-vs-aux tie grants core.
- Core drops req one cycle after grant while aux requests -> core_ack still pulses at T+3; aux is granted in the following IDLE cycle.
